// File: rtl/matmul_share_arbiter.sv
// matmul_share_arbiter: round-robin, tile-granular owner scheduler for one shared systolic matmul core
//
// Ports:
//   clk            clock
//   rst_n          synchronous active-low reset
//   i_req          per-requester level request, held until its tile work is finished
//   i_req_last     marks the requester's next tile as the last of its job (sampled in START)
//   i_core_done    accumulate-done level from the core (only its rising edge is used)
//   o_grant        one-hot owner, 0 when idle
//   o_grant_idx    owner index for the datapath mux select
//   o_core_rst_n   active-low flush to the core, low only in FLUSH
//   o_core_start   one-cycle tile start pulse, high only in START
//   o_tile_done    one-cycle pulse to the owner when a tile completes
//   o_job_done     one-cycle pulse to the owner when a last-flagged tile completes
//   o_busy         high whenever the scheduler is not idle
//   o_tiles_total  saturating count of completed tiles
module matmul_share_arbiter #(
    parameter int N_REQ        = 3,
    parameter int MAX_BURST    = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int TILE_CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ-1:0]         i_req_last,
    input  logic                     i_core_done,
    output logic [N_REQ-1:0]         o_grant,
    output logic [$clog2(N_REQ)-1:0] o_grant_idx,
    output logic                     o_core_rst_n,
    output logic                     o_core_start,
    output logic [N_REQ-1:0]         o_tile_done,
    output logic [N_REQ-1:0]         o_job_done,
    output logic                     o_busy,
    output logic [TILE_CNT_W-1:0]    o_tiles_total
);
    localparam int IDX_W   = $clog2(N_REQ);
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_START = 2'd2;
    localparam logic [1:0] S_RUN   = 2'd3;

    logic [1:0]            r_state;
    logic [N_REQ-1:0]      r_grant;
    logic [IDX_W-1:0]      r_grant_idx;
    logic [IDX_W-1:0]      r_ptr;
    logic [BURST_W-1:0]    r_burst_cnt;
    logic [FLUSH_W-1:0]    r_flush_cnt;
    logic                  r_last_flag;
    logic                  r_core_done_d;
    logic [N_REQ-1:0]      r_tile_done;
    logic [N_REQ-1:0]      r_job_done;
    logic [TILE_CNT_W-1:0] r_tiles_total;

    logic [IDX_W-1:0]      w_win;
    logic                  w_done_rise;
    logic                  w_others;
    logic                  w_burst_ok;
    logic                  w_cont;

    // Walk from the farthest candidate back to ptr+1 so the nearest set bit after ptr wins.
    always_comb begin
        w_win = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (i_req[IDX_W'((int'(r_ptr) + k) % N_REQ)]) w_win = IDX_W'((int'(r_ptr) + k) % N_REQ);
        end
    end

    assign w_done_rise = i_core_done & ~r_core_done_d;
    assign w_others    = |(i_req & ~r_grant);
    assign w_burst_ok  = (int'(r_burst_cnt) + 1) < MAX_BURST;
    // Keep the core only while the owner still wants it, its job is not finished,
    // and either the burst budget remains or nobody else is waiting.
    assign w_cont      = i_req[r_grant_idx] & ~r_last_flag & (w_burst_ok | ~w_others);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_ptr         <= IDX_W'(N_REQ - 1);
            r_burst_cnt   <= '0;
            r_flush_cnt   <= '0;
            r_last_flag   <= 1'b0;
            r_core_done_d <= 1'b0;
            r_tile_done   <= '0;
            r_job_done    <= '0;
            r_tiles_total <= '0;
        end else begin
            r_core_done_d <= i_core_done;
            r_tile_done   <= '0;
            r_job_done    <= '0;
            case (r_state)
                S_IDLE: begin
                    if (|i_req) begin
                        r_grant     <= N_REQ'(1) << w_win;
                        r_grant_idx <= w_win;
                        r_burst_cnt <= '0;
                        r_flush_cnt <= '0;
                        r_state     <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    r_flush_cnt <= r_flush_cnt + 1'b1;
                    if (r_flush_cnt == FLUSH_W'(FLUSH_CYCLES - 1)) r_state <= S_START;
                end
                S_START: begin
                    r_last_flag <= i_req_last[r_grant_idx];
                    r_state     <= S_RUN;
                end
                S_RUN: begin
                    if (w_done_rise) begin
                        r_tile_done <= r_grant;
                        r_job_done  <= r_last_flag ? r_grant : '0;
                        if (r_tiles_total != '1) r_tiles_total <= r_tiles_total + 1'b1;
                        if (w_cont) begin
                            r_state <= S_START;
                            if (w_burst_ok) r_burst_cnt <= r_burst_cnt + 1'b1;
                        end else begin
                            r_ptr   <= r_grant_idx;
                            r_grant <= '0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_grant       = r_grant;
    assign o_grant_idx   = r_grant_idx;
    assign o_core_rst_n  = r_state != S_FLUSH;
    assign o_core_start  = r_state == S_START;
    assign o_tile_done   = r_tile_done;
    assign o_job_done    = r_job_done;
    assign o_busy        = r_state != S_IDLE;
    assign o_tiles_total = r_tiles_total;
endmodule

// File: doc/matmul_share_arbiter.md
# matmul_share_arbiter

Round-robin scheduler that shares one systolic matmul core, with its ping-pong buffers and accumulator, between `N_REQ` projection requesters (Q/K/V heads). Ownership is granted at tile granularity. Between owners the block flushes the core through an internal reset, issues per-tile start pulses, and detects tile completion from the core's accumulate-done level. It sits between the per-head projection controllers and the shared core's control/mux inputs.

## Interface
- `N_REQ`, 3, number of requesters (≥2)
- `MAX_BURST`, 4, maximum consecutive tiles per grant while another requester waits
- `FLUSH_CYCLES`, 2, cycles `core_rst_n` is held low on an owner change (≥1)
- `TILE_CNT_W`, 8, width of the tile statistics counter

- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `req`  in  N_REQ  per-requester level request; held until tile work is finished
- `req_last`  in  N_REQ  marks the requester's next tile as the final tile of its job; sampled in START
- `core_done`  in  1  accumulate-done level from the core; only its rising edge is used
- `grant`  out  N_REQ  one-hot owner, 0 when idle
- `grant_idx`  out  $clog2(N_REQ)  owner index, for the datapath mux select
- `core_rst_n`  out  1  active-low flush to the core
- `core_start`  out  1  one-cycle tile start pulse
- `tile_done`  out  N_REQ  one-cycle pulse to the owner when a tile completes
- `job_done`  out  N_REQ  one-cycle pulse when a tile flagged last completes
- `busy`  out  1  high whenever state ≠ IDLE
- `tiles_total`  out  TILE_CNT_W  saturating count of completed tiles

## Operation
- States: IDLE, FLUSH, START, RUN.
- `core_rst_n = (state≠FLUSH)`. `core_start = (state==START)`. Both are decoded from the state register only.
- IDLE, any `req` set:
  - Winner is the first set bit searching from `ptr+1` upward, wrapping modulo `N_REQ`.
  - Load `grant`/`grant_idx`, set `burst_cnt`←0 and `flush_cnt`←0, go to FLUSH.
- FLUSH: increment `flush_cnt`. After `FLUSH_CYCLES` cycles in FLUSH, go to START.
- START: one cycle. Latch `last_flag`←`req_last[grant_idx]`, go to RUN.
- RUN: wait for a `core_done` rising edge (`core_done & ~core_done_d`). On the edge, all in the same edge:
  - Pulse `tile_done[grant_idx]`.
  - If `last_flag`, also pulse `job_done[grant_idx]`.
  - `tiles_total`+1, saturating at all-ones.
- Continue decision at the done edge. Let `others = |(req & ~grant)`.
  - Continue when `req[owner] & ~last_flag & (burst_cnt+1 < MAX_BURST | ~others)`.
  - On continue: go to START with no flush. Set `burst_cnt`←`burst_cnt+1`, saturating at `MAX_BURST-1`.
  - Otherwise release: `ptr`←`grant_idx`, `grant`←0, go to IDLE.
- `req[owner]` dropping during FLUSH/START/RUN has no effect until the next done edge. The in-flight tile always completes.
- `core_done` rising edges outside RUN are ignored. `core_done_d` updates every cycle, so a level already high on entry to RUN does not count as an edge.
- Reset values:
  - `grant`=0, `grant_idx`=0, `core_rst_n`=1, `core_start`=0.
  - `tile_done`=0, `job_done`=0, `busy`=0, `tiles_total`=0.
  - Internal: state=IDLE, `ptr`=`N_REQ-1` (requester 0 has first priority), `core_done_d`=0.
- Reset mid-operation: all of the above take effect at the next edge with `rst_n` low. The in-flight tile is abandoned with no `tile_done`.

## Timing
- All outputs are registered or decoded from registers. There is no combinational path from inputs to outputs.
- With `req` sampled at edge 0 in IDLE:
  - `grant`/`busy` are valid after edge 0.
  - `core_rst_n` is low for `FLUSH_CYCLES` cycles.
  - `core_start` is high for the single cycle after edge `FLUSH_CYCLES`.
  - RUN begins after edge `FLUSH_CYCLES+1`.
- `core_done` rising edge sampled at edge t in RUN:
  - `tile_done`/`job_done` are high for the cycle after edge t.
  - `core_start` of a continued tile is high in that same cycle.
- Release at edge t: `grant`=0 after t. The new winner's `grant` appears after edge t+1, so there is one IDLE cycle.
- Minimum owner-change overhead is `FLUSH_CYCLES+2` cycles. Same-owner back-to-back tile overhead is 1 cycle.

## Test plan
- **Single requester:** `FLUSH_CYCLES`=2, `req`=001. Required:
  - `grant`=001 after edge 0, `core_rst_n` low for 2 cycles, `core_start` pulse after edge 2.
  - `core_done` edge yields `tile_done`=001 one cycle later and `tiles_total`=1.
- **Round robin:** `req`=111 held, `req_last`=111. Grant order must be 001, 010, 100, 001. Each grant yields exactly one tile, one `job_done`, and a flush between owners.
- **Burst limit:** `req`=011, `req_last`=00, `MAX_BURST`=4. Required:
  - Owner 0 completes exactly 4 tiles, with no flush between them, then `grant`→010.
  - With only `req`=001, owner 0 continues past 4 tiles without release.
- **Last flag:** owner 0 with `req_last[0]`=1 at START. Done edge gives `job_done`=001 and release, even though `req[0]` is still high.
- **Spurious done:** `core_done` pulsed during FLUSH and START, and held high on entry to RUN. Required: no `tile_done`. Only the next low→high transition in RUN completes the tile.
- **Reset mid-RUN:** assert `rst_n`=0 for 1 cycle during RUN. Required:
  - All outputs return to reset values, with no `tile_done`.
  - With `req`=110 afterwards, the first grant is 010, since `ptr` was reset.
  - `tiles_total` restarts from 0.
